// File: rtl/alu_pkg.sv
// Shared encodings for the execute stage: ALU op codes, R-type funct codes and ALUOp values.
package alu_pkg;

  // ALU op: bit 2 selects B-invert with carry-in of 1.
  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpOr  = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b110;
  localparam logic [2:0] OpSlt = 3'b111;

  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;

  // ALUOp as {alu_op1, alu_op0}.
  typedef enum logic [1:0] {
    AluOpMem   = 2'b00,
    AluOpBeq   = 2'b01,
    AluOpRtype = 2'b10,
    AluOpBeqX  = 2'b11
  } alu_op_e;

endpackage

// File: rtl/alu_decode.sv
// Combinational ALU operation decoder driven by ALUOp and the R-type funct field.
module alu_decode
  import alu_pkg::*;
(
  input  logic       alu_op0_i,
  input  logic       alu_op1_i,
  input  logic [5:0] funct_i,
  output logic [2:0] op_o
);

  alu_op_e alu_op;
  assign alu_op = alu_op_e'({alu_op1_i, alu_op0_i});

  always_comb begin
    op_o = OpAdd;
    unique case (alu_op)
      AluOpBeq, AluOpBeqX: op_o = OpSub;
      AluOpMem:            op_o = OpAdd;
      AluOpRtype: begin
        unique case (funct_i)
          FunctAdd: op_o = OpAdd;
          FunctSub: op_o = OpSub;
          FunctAnd: op_o = OpAnd;
          FunctOr:  op_o = OpOr;
          FunctSlt: op_o = OpSlt;
          default:  op_o = OpAdd;
        endcase
      end
      default: op_o = OpAdd;
    endcase
  end

endmodule

// File: rtl/regfile.sv
// Register file with two combinational read ports and one synchronous write port; $0 reads 0.
module regfile #(
  parameter int unsigned Width = 32,
  parameter int unsigned NRegs = 32,
  parameter int unsigned AddrW = $clog2(NRegs)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [AddrW-1:0] rs_addr_i,
  input  logic [AddrW-1:0] rt_addr_i,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             we_i,
  output logic [Width-1:0] rs_data_o,
  output logic [Width-1:0] rt_data_o
);

  logic [Width-1:0] regs_q [NRegs];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NRegs); i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (wr_addr_i != '0)) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  // No write bypass: a same-cycle write shows up only after the edge.
  assign rs_data_o = (rs_addr_i == '0) ? '0 : regs_q[rs_addr_i];
  assign rt_data_o = (rt_addr_i == '0) ? '0 : regs_q[rt_addr_i];

endmodule

// File: rtl/reg_alu_core.sv
// Execute-stage core: register file, ALU op decoder and inline 32-bit ALU.
module reg_alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(NREGS)-1:0] rs_addr,
  input  logic [$clog2(NREGS)-1:0] rt_addr,
  input  logic [$clog2(NREGS)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     reg_write,
  input  logic                     alu_op0,
  input  logic                     alu_op1,
  input  logic [5:0]               funct,
  input  logic                     alu_src,
  input  logic [WIDTH-1:0]         imm,
  output logic [WIDTH-1:0]         read_data1,
  output logic [WIDTH-1:0]         read_data2,
  output logic [WIDTH-1:0]         alu_result,
  output logic                     zero,
  output logic                     cout
);

  logic [2:0]       op;
  logic [WIDTH-1:0] a, b, b_eff, sum;
  logic             carry, less;

  regfile #(
    .Width (WIDTH),
    .NRegs (NREGS)
  ) u_regfile (
    .clk_i     (clk),
    .rst_ni    (reset),
    .rs_addr_i (rs_addr),
    .rt_addr_i (rt_addr),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .we_i      (reg_write),
    .rs_data_o (read_data1),
    .rt_data_o (read_data2)
  );

  alu_decode u_alu_decode (
    .alu_op0_i (alu_op0),
    .alu_op1_i (alu_op1),
    .funct_i   (funct),
    .op_o      (op)
  );

  assign a     = read_data1;
  assign b     = alu_src ? imm : read_data2;
  assign b_eff = op[2] ? ~b : b;
  assign {carry, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op[2]};

  // Signed compare without relying on the overflowing sign of the difference.
  assign less = (a[WIDTH-1] & ~b[WIDTH-1]) |
                (~(a[WIDTH-1] ^ b[WIDTH-1]) & sum[WIDTH-1]);

  always_comb begin
    alu_result = '0;
    cout       = 1'b0;
    unique case (op)
      OpAnd: alu_result = a & b;
      OpOr:  alu_result = a | b;
      OpAdd, OpSub: begin
        alu_result = sum;
        cout       = carry;
      end
      OpSlt: begin
        alu_result = {{(WIDTH-1){1'b0}}, less};
        cout       = carry;
      end
      default: begin
        alu_result = '0;
        cout       = 1'b0;
      end
    endcase
  end

  assign zero = (alu_result == '0);

endmodule

// File: tb/tb_reg_alu_core.sv
// Directed self-checking bench for reg_alu_core with hand-computed expectations.
module tb_reg_alu_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_addr, rt_addr, wr_addr;
  logic [31:0] wr_data, imm;
  logic        reg_write, alu_op0, alu_op1, alu_src;
  logic [5:0]  funct;
  logic [31:0] read_data1, read_data2, alu_result;
  logic        zero, cout;

  int n_checks = 0;
  int n_errors = 0;

  reg_alu_core dut (
    .clk        (clk),
    .reset      (reset),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .reg_write  (reg_write),
    .alu_op0    (alu_op0),
    .alu_op1    (alu_op1),
    .funct      (funct),
    .alu_src    (alu_src),
    .imm        (imm),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .alu_result (alu_result),
    .zero       (zero),
    .cout       (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    wr_addr   = addr;
    wr_data   = data;
    reg_write = 1'b1;
    @(posedge clk);
    #1;
    reg_write = 1'b0;
  endtask

  task automatic set_aluop(input logic [1:0] v);
    {alu_op1, alu_op0} = v;
  endtask

  typedef struct {
    string      tag;
    logic [5:0] fn;
    logic [31:0] res;
  } rvec_t;

  rvec_t rvecs[6];

  initial begin
    reset = 1'b0; rs_addr = '0; rt_addr = '0; wr_addr = '0; wr_data = '0; imm = '0;
    reg_write = 1'b0; alu_op0 = 1'b0; alu_op1 = 1'b0; alu_src = 1'b0; funct = '0;
    #12;
    reset = 1'b1;

    // Reset state
    rs_addr = 5'd1; rt_addr = 5'd2;
    #1;
    check("reset_rd1", read_data1, 32'h0);
    check("reset_res", alu_result, 32'h0);
    check("reset_zero", {31'b0, zero}, 32'd1);

    // Reset then load: ALU result is combinational during the write cycle
    @(negedge clk);
    wr_addr = 5'd1; wr_data = 32'h10101010; reg_write = 1'b1;
    rs_addr = 5'd0; imm = 32'd14; alu_src = 1'b1; set_aluop(2'b00);
    #1;
    check("lw_addr_res", alu_result, 32'd14);
    rs_addr = 5'd1;
    #1;
    check("load_before_edge", read_data1, 32'h0);
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    check("load_after_edge", read_data1, 32'h10101010);

    // R-type ops with $2=7, $3=5
    write_reg(5'd2, 32'd7);
    write_reg(5'd3, 32'd5);
    rs_addr = 5'd2; rt_addr = 5'd3; alu_src = 1'b0; set_aluop(2'b10);
    rvecs[0] = '{"r_add", 6'b100000, 32'd12};
    rvecs[1] = '{"r_sub", 6'b100010, 32'd2};
    rvecs[2] = '{"r_and", 6'b100100, 32'd5};
    rvecs[3] = '{"r_or",  6'b100101, 32'd7};
    rvecs[4] = '{"r_slt", 6'b101010, 32'd0};
    rvecs[5] = '{"r_unk", 6'b000000, 32'd12};
    foreach (rvecs[i]) begin
      funct = rvecs[i].fn;
      #1;
      check(rvecs[i].tag, alu_result, rvecs[i].res);
    end
    funct = 6'b100010;
    #1;
    check("sub_cout", {31'b0, cout}, 32'd1);
    rs_addr = 5'd3; rt_addr = 5'd2; funct = 6'b101010;
    #1;
    check("slt_swap", alu_result, 32'd1);
    check("slt_swap_cout", {31'b0, cout}, 32'd0);

    // Signed slt and carry
    write_reg(5'd2, 32'hFFFFFFFF);
    write_reg(5'd3, 32'd1);
    rs_addr = 5'd2; rt_addr = 5'd3; funct = 6'b101010;
    #1;
    check("slt_signed", alu_result, 32'd1);
    rs_addr = 5'd3; rt_addr = 5'd2;
    #1;
    check("slt_signed_swap", alu_result, 32'd0);
    write_reg(5'd6, 32'h80000000);
    rs_addr = 5'd6; rt_addr = 5'd3;
    #1;
    check("slt_overflow", alu_result, 32'd1);
    rs_addr = 5'd2; set_aluop(2'b00); alu_src = 1'b1; imm = 32'd1;
    #1;
    check("add_wrap_res", alu_result, 32'd0);
    check("add_wrap_zero", {31'b0, zero}, 32'd1);
    check("add_wrap_cout", {31'b0, cout}, 32'd1);

    // beq
    alu_src = 1'b0; set_aluop(2'b01); rs_addr = 5'd3; rt_addr = 5'd3;
    #1;
    check("beq_eq_zero", {31'b0, zero}, 32'd1);
    rs_addr = 5'd2;
    #1;
    check("beq_ne_zero", {31'b0, zero}, 32'd0);
    set_aluop(2'b11); funct = 6'b100100;
    #1;
    check("aluop11_sub", alu_result, 32'hFFFFFFFE);

    // Register 0 and no bypass
    write_reg(5'd0, 32'hDEAD);
    rs_addr = 5'd0;
    #1;
    check("r0_read", read_data1, 32'h0);
    write_reg(5'd4, 32'h1234);
    @(negedge clk);
    wr_addr = 5'd4; wr_data = 32'h5678; reg_write = 1'b1; rt_addr = 5'd4;
    #1;
    check("bypass_old", read_data2, 32'h1234);
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    check("bypass_new", read_data2, 32'h5678);

    // Reset mid-operation, then a write edge while held in reset
    @(negedge clk);
    rs_addr = 5'd1; rt_addr = 5'd4; set_aluop(2'b00); alu_src = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("mid_reset_rd1", read_data1, 32'h0);
    check("mid_reset_rd2", read_data2, 32'h0);
    check("mid_reset_zero", {31'b0, zero}, 32'd1);
    wr_addr = 5'd5; wr_data = 32'hAAAA; reg_write = 1'b1;
    @(posedge clk);
    #1;
    reg_write = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    rs_addr = 5'd5;
    @(posedge clk);
    #1;
    check("write_in_reset", read_data1, 32'h0);
    rs_addr = 5'd6;
    #1;
    check("cleared_r6", read_data1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
